// File: rtl/midi_voice_allocator.sv
// Single-channel MIDI note allocator: parses note-on/off with running status and drives
// gate/note/velocity per voice. Define MIDI_ALLOC_SUSTAIN_EN to add CC64 sustain-pedal handling.
module midi_voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int RANK_BITS  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_byte,
    input  logic [3:0]              channel,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [NUM_VOICES*8-1:0] voice_note,
    output logic [NUM_VOICES*8-1:0] voice_velocity,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, D1, D2} state_t;

    state_t                state, state_next;
    logic                  latch_status, clear_status, latch_data1, exec;
    logic [3:0]            status_hi;
    logic                  accept;
    logic [6:0]            data1;
    logic [6:0]            vel;
    logic                  is_on, is_off, release_all, pedal_on;

    logic [NUM_VOICES-1:0] gate, sust, pend;
    logic [6:0]            note_r [NUM_VOICES];
    logic [6:0]            vel_r  [NUM_VOICES];
    logic [RANK_BITS-1:0]  rank   [NUM_VOICES];

    logic [NUM_VOICES-1:0] held, free, off_hit, oldest;
    logic [NUM_VOICES-1:0] held_oh, free_oh, tgt_oh;
    logic [RANK_BITS-1:0]  tgt_rank;
    logic                  tgt_gate;

    // Parser: realtime bytes are transparent, system-common bytes drop running status.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        latch_status = 1'b0;
        clear_status = 1'b0;
        latch_data1  = 1'b0;
        exec         = 1'b0;
        if (rx_valid) begin
            if (rx_byte[7:3] == 5'b11111) begin
                state_next = state;
            end else if (rx_byte[7:4] == 4'hF) begin
                clear_status = 1'b1;
                state_next   = IDLE;
            end else if (rx_byte[7]) begin
                latch_status = 1'b1;
                state_next   = D1;
            end else begin
                case (state)
                    D1: begin
                        latch_data1 = 1'b1;
                        state_next  = D2;
                    end
                    D2: begin
                        exec       = 1'b1;
                        state_next = D1;
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_hi <= 4'h0;
            accept    <= 1'b0;
            data1     <= 7'h0;
        end else begin
            if (clear_status) begin
                accept <= 1'b0;
            end else if (latch_status) begin
                status_hi <= rx_byte[7:4];
                accept    <= (rx_byte[7:4] == 4'h8 || rx_byte[7:4] == 4'h9 ||
                              rx_byte[7:4] == 4'hB) && (rx_byte[3:0] == channel);
            end
            if (latch_data1) data1 <= rx_byte[6:0];
        end
    end

    assign vel    = rx_byte[6:0];
    assign is_on  = exec && accept && status_hi == 4'h9 && vel != 7'd0;
    assign is_off = exec && accept && (status_hi == 4'h8 || (status_hi == 4'h9 && vel == 7'd0));

    // Voice selection: same-note reuse, else lowest free index, else the oldest voice.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            held[i]    = (gate[i] || sust[i]) && note_r[i] == data1;
            free[i]    = !gate[i] && !sust[i];
            off_hit[i] = gate[i] && note_r[i] == data1;
            oldest[i]  = rank[i] == RANK_BITS'(NUM_VOICES - 1);
        end
        held_oh = held & (~held + NUM_VOICES'(1));
        free_oh = free & (~free + NUM_VOICES'(1));
        if (|held)      tgt_oh = held_oh;
        else if (|free) tgt_oh = free_oh;
        else            tgt_oh = oldest;
        tgt_rank = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (tgt_oh[i]) tgt_rank = rank[i];
        end
        tgt_gate = |(tgt_oh & gate);
    end

`ifdef MIDI_ALLOC_SUSTAIN_EN
    logic is_cc, pedal;

    assign is_cc       = exec && accept && status_hi == 4'hB && data1 == 7'd64;
    assign release_all = is_cc && !vel[6];
    assign pedal_on    = pedal;

    always_ff @(posedge clk) begin
        if (rst) begin
            pedal <= 1'b0;
            sust  <= '0;
        end else begin
            if (is_cc)             pedal <= vel[6];
            if (is_on)             sust  <= sust & ~tgt_oh;
            if (is_off && pedal)   sust  <= sust | off_hit;
            if (release_all)       sust  <= '0;
        end
    end
`else
    assign sust        = '0;
    assign release_all = 1'b0;
    assign pedal_on    = 1'b0;
`endif

    // Voice state: a steal or retrigger of a gated voice holds the gate low for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate <= '0;
            pend <= '0;
            busy <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_r[i] <= 7'h0;
                vel_r[i]  <= 7'h0;
                rank[i]   <= RANK_BITS'(i);
            end
        end else begin
            busy <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (pend[i]) begin
                    gate[i] <= 1'b1;
                    pend[i] <= 1'b0;
                end
            end
            if (is_on) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (tgt_oh[i]) begin
                        note_r[i] <= data1;
                        vel_r[i]  <= vel;
                        rank[i]   <= '0;
                        if (tgt_gate) begin
                            gate[i] <= 1'b0;
                            pend[i] <= 1'b1;
                        end else begin
                            gate[i] <= 1'b1;
                        end
                    end else if (rank[i] < tgt_rank) begin
                        rank[i] <= rank[i] + RANK_BITS'(1);
                    end
                end
                if (tgt_gate) busy <= 1'b1;
            end
            if (is_off && !pedal_on) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (off_hit[i]) gate[i] <= 1'b0;
                end
            end
            if (release_all) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (sust[i]) gate[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        voice_gate = gate;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[8*i +: 8]     = {1'b0, note_r[i]};
            voice_velocity[8*i +: 8] = {vel_r[i], 1'b0};
        end
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Scoreboard bench for midi_voice_allocator: a behavioural model predicts the outputs one and
// two cycles after every received byte; a negedge monitor pops and compares them.
module tb_midi_voice_allocator;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst, rx_valid;
    logic [7:0]     rx_byte;
    logic [3:0]     channel;
    logic [N-1:0]   voice_gate;
    logic [N*8-1:0] voice_note, voice_velocity;
    logic           busy;

    midi_voice_allocator #(.NUM_VOICES(N), .RANK_BITS(3)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .channel(channel),
        .voice_gate(voice_gate), .voice_note(voice_note), .voice_velocity(voice_velocity),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int             cyc;
        logic [N-1:0]   gate;
        logic [N*8-1:0] note;
        logic [N*8-1:0] vel;
        logic           busy;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    // Reference model state
    bit         m_gate [N];
    bit         m_sust [N];
    logic [6:0] m_note [N];
    logic [6:0] m_vel  [N];
    int         m_rank [N];
    bit         m_pedal;
    int         p_state;
    logic [3:0] p_hi;
    bit         p_acc;
    logic [6:0] p_d1;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_gate[i] = 0; m_sust[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_rank[i] = i;
        end
        m_pedal = 0; p_state = 0; p_hi = 0; p_acc = 0; p_d1 = 0;
    endtask

    function automatic exp_t snap(input int c, input int pulse);
        exp_t e;
        e.cyc  = c;
        e.busy = (pulse >= 0);
        for (int i = 0; i < N; i++) begin
            e.gate[i]        = m_gate[i] && (i != pulse);
            e.note[8*i +: 8] = {1'b0, m_note[i]};
            e.vel[8*i +: 8]  = {m_vel[i], 1'b0};
        end
        return e;
    endfunction

    task automatic model_note_on(input logic [6:0] nt, input logic [6:0] vl, output int pulse);
        int hit = -1;
        int old;
        for (int i = 0; i < N; i++)
            if ((m_gate[i] || m_sust[i]) && m_note[i] == nt) hit = i;
        if (hit < 0)
            for (int i = N - 1; i >= 0; i--)
                if (!m_gate[i] && !m_sust[i]) hit = i;
        if (hit < 0)
            for (int i = 0; i < N; i++)
                if (m_rank[i] == N - 1) hit = i;
        pulse = m_gate[hit] ? hit : -1;
        old = m_rank[hit];
        for (int i = 0; i < N; i++)
            if (m_rank[i] < old) m_rank[i]++;
        m_rank[hit] = 0;
        m_note[hit] = nt;
        m_vel[hit]  = vl;
        m_sust[hit] = 0;
        m_gate[hit] = 1;
    endtask

    task automatic model_byte(input logic [7:0] b, output int pulse);
        logic [6:0] d;
        pulse = -1;
        d = b[6:0];
        if (b >= 8'hF8) begin
            pulse = -1;
        end else if (b >= 8'hF0) begin
            p_state = 0; p_acc = 0;
        end else if (b[7]) begin
            p_hi    = b[7:4];
            p_acc   = (b[7:4] == 4'h8 || b[7:4] == 4'h9 || b[7:4] == 4'hB) && b[3:0] == channel;
            p_state = 1;
        end else if (p_state == 1) begin
            p_d1 = d; p_state = 2;
        end else if (p_state == 2) begin
            p_state = 1;
            if (p_acc && p_hi == 4'h9 && d != 0) begin
                model_note_on(p_d1, d, pulse);
            end else if (p_acc && (p_hi == 4'h8 || p_hi == 4'h9)) begin
                for (int i = 0; i < N; i++)
                    if (m_gate[i] && m_note[i] == p_d1) begin
                        if (m_pedal) m_sust[i] = 1;
                        else m_gate[i] = 0;
                    end
            end
`ifdef MIDI_ALLOC_SUSTAIN_EN
            else if (p_acc && p_hi == 4'hB && p_d1 == 7'd64) begin
                m_pedal = (d >= 7'd64);
                if (!m_pedal)
                    for (int i = 0; i < N; i++)
                        if (m_sust[i]) begin m_sust[i] = 0; m_gate[i] = 0; end
            end
`endif
        end
    endtask

    // Drive one byte (called #1 after a posedge) and queue the T+1 / T+2 predictions.
    task automatic send(input logic [7:0] b);
        int pulse;
        model_byte(b, pulse);
        q.push_back(snap(cyc + 1, pulse));
        q.push_back(snap(cyc + 2, -1));
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_list(input logic [7:0] bytes[$]);
        foreach (bytes[k]) send(bytes[k]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gate"}, 64'(voice_gate), 64'd0);
        chk({tag, "_note"}, 64'(voice_note), 64'd0);
        chk({tag, "_vel"},  64'(voice_velocity), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            if (mon_e.cyc < cyc) begin
                chk("sb_stale", 64'(cyc), 64'(mon_e.cyc));
            end else begin
                chk("gate", 64'(voice_gate), 64'(mon_e.gate));
                chk("note", 64'(voice_note), 64'(mon_e.note));
                chk("vel",  64'(voice_velocity), 64'(mon_e.vel));
                chk("busy", 64'(busy), 64'(mon_e.busy));
            end
        end
    end

    initial begin
        int pulse;
        rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; channel = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_zero("reset");

        // data bytes with no running status are ignored
        send_list('{8'h3C, 8'h64});
        // basic note-on / note-off
        send_list('{8'h90, 8'h3C, 8'h64, 8'h80, 8'h3C, 8'h00});
        // running status, note-off via velocity 0
        send_list('{8'h90, 8'h40, 8'h50, 8'h43, 8'h50, 8'h40, 8'h00});

        // stealing the oldest voice
        do_reset();
        send_list('{8'h90, 8'h3C, 8'h40, 8'h3E, 8'h41, 8'h40, 8'h42, 8'h41, 8'h43,
                    8'h43, 8'h44, 8'h45, 8'h45});

        // channel filter, realtime transparency, system-common and status abort
        do_reset();
        channel = 4'd2;
        send_list('{8'h91, 8'h3C, 8'h64});
        send_list('{8'h92, 8'hF8, 8'h3C, 8'hFE, 8'h64});
        send_list('{8'hF0, 8'h3E, 8'h64});
        send_list('{8'h92, 8'h40, 8'h92, 8'h41, 8'h64});
        send_list('{8'hB2, 8'h07, 8'h64});

        // same-note retrigger
        do_reset();
        channel = 4'd0;
        send_list('{8'h90, 8'h3C, 8'h64, 8'h3C, 8'h50});

`ifdef MIDI_ALLOC_SUSTAIN_EN
        do_reset();
        send_list('{8'hB0, 8'h40, 8'h7F, 8'h90, 8'h3C, 8'h64, 8'h3E, 8'h64,
                    8'h80, 8'h3C, 8'h00, 8'hB0, 8'h40, 8'h00});
`endif

        // reset asserted during the retrigger cycle wins
        do_reset();
        send_list('{8'h90, 8'h3C, 8'h64, 8'h3C});
        model_byte(8'h50, pulse);
        q.push_back(snap(cyc + 1, pulse));
        rx_valid = 1'b1; rx_byte = 8'h50;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk_zero("rst_retrig");

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drain", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
